// File: rtl/fractal_pkg.sv
// Shared types and default geometry for the fractal frame pipeline.
// Screen, pixel and engine sizing plus the dispatcher state encoding.
package fractal_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } dispatch_state_t;

   localparam int SCREEN_W_DEF   = 640;
   localparam int SCREEN_H_DEF   = 480;
   localparam int CENTER_X       = SCREEN_W_DEF / 2;
   localparam int CENTER_Y       = SCREEN_H_DEF / 2;
   localparam int PIXEL_W_DEF    = 10;
   localparam int ENGINE_W_DEF   = 25;
   localparam int NUM_ENGINES_DEF = 4;

endpackage

// File: rtl/pixel_dispatch_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Purely combinational; one-hot grant plus binary index.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);

   int j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      j         = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any_grant && req[j]) begin
            any_grant = 1'b1;
            grant_idx = IW'(j);
            grant[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_dispatch_ctrl.sv
// Raster-order pixel scheduler feeding the mapper and engine pool.
// Optional perf counters: define DISPATCH_PERF_EN.
module pixel_dispatch_ctrl
   import fractal_pkg::*;
#(
   parameter int PIXEL_DATA_WIDTH  = PIXEL_W_DEF,
   parameter int ENGINE_DATA_WIDTH = ENGINE_W_DEF,
   parameter int SCREEN_WIDTH      = SCREEN_W_DEF,
   parameter int SCREEN_HEIGHT     = SCREEN_H_DEF,
   parameter int NUM_ENGINES       = NUM_ENGINES_DEF,
   localparam int OW = $clog2(NUM_ENGINES + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         frame_start,
   input  logic [2:0]                   zoom_in,
   input  logic [ENGINE_DATA_WIDTH-1:0] x_offset_in,
   input  logic [ENGINE_DATA_WIDTH-1:0] y_offset_in,
   input  logic                         full_queue,
   input  logic [NUM_ENGINES-1:0]       engine_busy,
   input  logic [NUM_ENGINES-1:0]       engine_done,
   output logic                         map_en,
   output logic [PIXEL_DATA_WIDTH-1:0]  pixel_x,
   output logic [PIXEL_DATA_WIDTH-1:0]  pixel_y,
   output logic [2:0]                   zoom,
   output logic [ENGINE_DATA_WIDTH-1:0] x_offset,
   output logic [ENGINE_DATA_WIDTH-1:0] y_offset,
   output logic [NUM_ENGINES-1:0]       engine_start,
   output logic [OW-1:0]                outstanding,
   output logic                         busy,
`ifdef DISPATCH_PERF_EN
   output logic [31:0]                  frame_cycles,
   output logic [31:0]                  stall_cycles,
`endif
   output logic                         frame_done
);

   localparam int IW = $clog2(NUM_ENGINES);

   dispatch_state_t             state;
   logic [PIXEL_DATA_WIDTH-1:0] x_cnt, y_cnt;
   logic [NUM_ENGINES-1:0]      reserved, res_nxt, eligible, grant_oh;
   logic [IW-1:0]               ptr, grant_idx;
   logic                        any_grant, issue, last_x, last_px;
   logic [OW-1:0]               cnt_nxt;

   assign eligible = ~engine_busy & ~reserved;
   assign issue    = (state == SCAN) && !full_queue && any_grant;
   assign last_x   = x_cnt == PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
   assign last_px  = last_x && y_cnt == PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
   assign map_en   = issue;
   assign pixel_x  = x_cnt;
   assign pixel_y  = y_cnt;

   rr_arbiter #(.N(NUM_ENGINES)) u_arb (
      .req       (eligible),
      .ptr       (ptr),
      .grant     (grant_oh),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Done for an unreserved engine drops out here and never moves the count.
   always_comb begin
      res_nxt = (reserved & ~engine_done) | (issue ? grant_oh : '0);
      cnt_nxt = '0;
      for (int i = 0; i < NUM_ENGINES; i++)
         cnt_nxt = cnt_nxt + OW'(res_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         x_cnt        <= '0;
         y_cnt        <= '0;
         reserved     <= '0;
         ptr          <= '0;
         engine_start <= '0;
         outstanding  <= '0;
         zoom         <= '0;
         x_offset     <= '0;
         y_offset     <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         reserved     <= res_nxt;
         outstanding  <= cnt_nxt;
         engine_start <= issue ? grant_oh : '0;
         if (issue) begin
            ptr <= (grant_idx == IW'(NUM_ENGINES - 1)) ? '0 : grant_idx + 1'b1;
            if (last_x) begin
               x_cnt <= '0;
               y_cnt <= last_px ? '0 : y_cnt + 1'b1;
            end else begin
               x_cnt <= x_cnt + 1'b1;
            end
         end
         unique case (state)
            IDLE: if (frame_start) begin
               state    <= SCAN;
               busy     <= 1'b1;
               zoom     <= zoom_in;
               x_offset <= x_offset_in;
               y_offset <= y_offset_in;
               x_cnt    <= '0;
               y_cnt    <= '0;
            end
            SCAN: if (issue && last_px) state <= DRAIN;
            // A start still in flight means its engine is reserved but not yet running.
            DRAIN: if (res_nxt == '0 && engine_start == '0) begin
               state      <= DONE;
               frame_done <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef DISPATCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cycles <= '0;
         stall_cycles <= '0;
      end else if (state == IDLE && frame_start) begin
         frame_cycles <= '0;
         stall_cycles <= '0;
      end else begin
         if (state == SCAN || state == DRAIN) frame_cycles <= frame_cycles + 1;
         if (state == SCAN && !issue) stall_cycles <= stall_cycles + 1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_dispatch_ctrl.sv
// Randomized bench for pixel_dispatch_ctrl on a 4x2 screen, 4 engines.
// Reference model tracks frame progress as a pixel index and engine set.
module tb_pixel_dispatch_ctrl;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int N  = 4;
   localparam int PW = 10;
   localparam int EW = 25;
   localparam int OW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic [2:0]    zoom_in;
   logic [EW-1:0] x_offset_in, y_offset_in;
   logic          full_queue;
   logic [N-1:0]  engine_busy, engine_done;
   logic          map_en;
   logic [PW-1:0] pixel_x, pixel_y;
   logic [2:0]    zoom;
   logic [EW-1:0] x_offset, y_offset;
   logic [N-1:0]  engine_start;
   logic [OW-1:0] outstanding;
   logic          busy, frame_done;

   pixel_dispatch_ctrl #(
      .PIXEL_DATA_WIDTH  (PW),
      .ENGINE_DATA_WIDTH (EW),
      .SCREEN_WIDTH      (W),
      .SCREEN_HEIGHT     (H),
      .NUM_ENGINES       (N)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_start  (frame_start),
      .zoom_in      (zoom_in),
      .x_offset_in  (x_offset_in),
      .y_offset_in  (y_offset_in),
      .full_queue   (full_queue),
      .engine_busy  (engine_busy),
      .engine_done  (engine_done),
      .map_en       (map_en),
      .pixel_x      (pixel_x),
      .pixel_y      (pixel_y),
      .zoom         (zoom),
      .x_offset     (x_offset),
      .y_offset     (y_offset),
      .engine_start (engine_start),
      .outstanding  (outstanding),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: frame progress, engine reservations, pending start.
   bit            m_busy, m_done;
   int            m_idx, m_ptr, m_pend, frames;
   bit            m_res [N];
   logic [2:0]    m_zoom;
   logic [EW-1:0] m_xo, m_yo;
   int            eng_cnt [N];

   function automatic int res_count();
      int c = 0;
      for (int k = 0; k < N; k++) c += int'(m_res[k]);
      return c;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_idx = 0; m_ptr = 0; m_pend = -1;
      m_zoom = '0; m_xo = '0; m_yo = '0;
      for (int k = 0; k < N; k++) begin
         m_res[k]   = 0;
         eng_cnt[k] = 0;
      end
   endtask

   task automatic drive_inputs(input int stall_left);
      frame_start = ($urandom_range(0, 3) == 0);
      zoom_in     = 3'($urandom);
      x_offset_in = EW'($urandom);
      y_offset_in = EW'($urandom);
      full_queue  = (stall_left > 0) || ($urandom_range(0, 4) == 0);
      for (int k = 0; k < N; k++) begin
         engine_busy[k] = 1'b0;
         engine_done[k] = 1'b0;
         if (eng_cnt[k] > 0) begin
            engine_busy[k] = 1'b1;
            eng_cnt[k]--;
            if (eng_cnt[k] == 0) engine_done[k] = 1'b1;
         end else if (!m_res[k]) begin
            engine_busy[k] = ($urandom_range(0, 5) == 0);
            engine_done[k] = ($urandom_range(0, 7) == 0);
         end
      end
   endtask

   task automatic check_and_step();
      int g, pend_before, ex_pend;
      bit was_drain;
      g = -1;
      if (m_busy && !m_done && m_idx < W * H && !full_queue)
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (g < 0 && !engine_busy[k] && !m_res[k]) g = k;
         end
      check("map_en", 32'(map_en), 32'(g >= 0));
      if (g >= 0) begin
         check("pixel_x", 32'(pixel_x), 32'(m_idx % W));
         check("pixel_y", 32'(pixel_y), 32'(m_idx / W));
      end
      ex_pend = (m_pend >= 0) ? (1 << m_pend) : 0;
      check("engine_start", 32'(engine_start), 32'(ex_pend));
      check("outstanding", 32'(outstanding), 32'(res_count()));
      check("busy", 32'(busy), 32'(m_busy));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("zoom", 32'(zoom), 32'(m_zoom));
      check("x_offset", 32'(x_offset), 32'(m_xo));
      check("y_offset", 32'(y_offset), 32'(m_yo));
      for (int k = 0; k < N; k++)
         if (engine_start[k]) eng_cnt[k] = $urandom_range(1, 4);
      was_drain   = m_busy && !m_done && m_idx == W * H;
      pend_before = m_pend;
      for (int k = 0; k < N; k++)
         if (engine_done[k]) m_res[k] = 0;
      m_pend = g;
      if (g >= 0) begin
         m_res[g] = 1;
         m_ptr    = (g + 1) % N;
         m_idx++;
      end
      if (m_done) begin
         m_done = 0;
         m_busy = 0;
         frames++;
      end else if (was_drain && res_count() == 0 && pend_before < 0) begin
         m_done = 1;
      end else if (!m_busy && frame_start) begin
         m_busy = 1;
         m_idx  = 0;
         m_zoom = zoom_in;
         m_xo   = x_offset_in;
         m_yo   = y_offset_in;
      end
   endtask

   initial begin
      int  stall_left;
      bit  did_stall, did_reset;
      stall_left = 0; did_stall = 0; did_reset = 0; frames = 0;
      reset = 1'b1; frame_start = 1'b0; zoom_in = '0;
      x_offset_in = '0; y_offset_in = '0; full_queue = 1'b0;
      engine_busy = '0; engine_done = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outstanding", 32'(outstanding), 32'd0);
      check("rst_engine_start", 32'(engine_start), 32'd0);
      check("rst_pixel", 32'({pixel_x, pixel_y}), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (!did_stall && frames >= 1 && m_busy && !m_done && m_idx == 2) begin
            stall_left = 5;
            did_stall  = 1;
         end
         drive_inputs(stall_left);
         if (stall_left > 0) stall_left--;
         if (!did_reset && frames >= 3 && m_busy && !m_done && m_idx == W + 1) begin
            frame_start = 1'b0;
            reset       = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            model_reset();
            did_reset = 1;
            check("rst_mid_busy", 32'(busy), 32'd0);
            check("rst_mid_outstanding", 32'(outstanding), 32'd0);
            check("rst_mid_x_offset", 32'(x_offset), 32'd0);
            check("rst_mid_pixel", 32'({pixel_x, pixel_y}), 32'd0);
            check("rst_mid_engine_start", 32'(engine_start), 32'd0);
            continue;
         end
         #1;
         check_and_step();
         @(posedge clk);
         #1;
      end
      check("frames_completed", 32'(frames >= 20), 32'd1);
      check("mid_reset_hit", 32'(did_reset), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
